// File: rtl/alu_ctrl_pkg.sv
// Shared ALUControl codes, FSM encoding and request payload type for alu_share_arbiter.
package alu_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'b0011;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'b0100;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'b0101;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'b0111;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'b1000;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'b1001;
    localparam logic [OP_W-1:0] ALU_LUI  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_req_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response channels between NUM_REQ requesters and the shared ALU arbiter.
interface alu_share_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
) ();
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ*4-1:0]  req_op;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_ready;
    logic [31:0]           resp_result;
    logic                  resp_zero;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_result, resp_zero
    );
endinterface

// File: rtl/alu.sv
// Core integer ALU, purely combinational; clk/reset_n exist only for port compatibility.
module alu
    import alu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   alu_control,
    output logic [DATA_W-1:0] result,
    output logic              zero
);
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset_n;

    // Undefined control codes yield zero
    always_comb begin
        result = '0;
        case (alu_control)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SRL:  result = a >> b[4:0];
            ALU_SUB:  result = a - b;
            ALU_SRA:  result = DATA_W'($signed(a) >>> b[4:0]);
            ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'd0, a < b};
            ALU_LUI:  result = b;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/alu_share_arbiter_arb_pick.sv
// Winner selection for alu_share_arbiter: fixed priority, or round-robin
// when ALU_ARB_ROUND_ROBIN_EN is defined.
module alu_arb_pick
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_valid
);
`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Scan starts one past the last winner and wraps around
    always_comb begin
        int unsigned        cand;
        logic [NUM_REQ-1:0] vbits;
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        cand      = 0;
        vbits     = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand  = (32'(rr_ptr) + k) % NUM_REQ;
            vbits = req_valid >> cand;
            if (!any_valid && vbits[0]) begin
                any_valid = 1'b1;
                idx       = IDX_W'(cand);
                grant     = NUM_REQ'(1) << cand;
            end
        end
    end
`else
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;

    // Lowest valid index wins
    always_comb begin
        logic [NUM_REQ-1:0] vbits;
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        vbits     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            vbits = req_valid >> k;
            if (!any_valid && vbits[0]) begin
                any_valid = 1'b1;
                idx       = IDX_W'(k);
                grant     = NUM_REQ'(1) << k;
            end
        end
    end
`endif
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters: accept, execute one cycle, respond.
// Optional macro ALU_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module alu_share_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    alu_share_arbiter_if.slave bus,
    output logic               busy,
    output logic [IDX_W-1:0]   grant_idx
);
    arb_state_e         state_q, state_d;
    alu_req_t           op_q, op_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [NUM_REQ-1:0] req_ready_c;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [IDX_W-1:0]   rr_ptr;

    logic [DATA_W-1:0]  alu_result;
    logic               alu_zero;

    logic [DATA_W-1:0]  sel_a, sel_b;
    logic [OP_W-1:0]    sel_op;
    logic [NUM_REQ-1:0] resp_ready_sh;
    logic               resp_hs;

    alu_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_grant),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q;

    // Pointer moves only on an accepted grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
        end else if (state_q == IDLE && pick_any) begin
            rr_ptr_q <= pick_idx;
        end
    end

    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = IDX_W'(NUM_REQ - 1);
`endif

    alu u_alu (
        .clk         (clk),
        .reset_n     (reset_n),
        .a           (op_q.a),
        .b           (op_q.b),
        .alu_control (op_q.op),
        .result      (alu_result),
        .zero        (alu_zero)
    );

    assign sel_a  = DATA_W'(bus.req_a  >> (DATA_W * pick_idx));
    assign sel_b  = DATA_W'(bus.req_b  >> (DATA_W * pick_idx));
    assign sel_op = OP_W'(bus.req_op   >> (OP_W * pick_idx));

    // Only the granted requester's resp_ready can complete the response
    assign resp_ready_sh = bus.resp_ready >> grant_idx_q;
    assign resp_hs       = resp_ready_sh[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            resp_valid_q <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            busy_q       <= 1'b0;
            grant_idx_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            resp_valid_q <= resp_valid_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            busy_q       <= busy_d;
            grant_idx_q  <= grant_idx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        resp_valid_d = resp_valid_q;
        result_d     = result_q;
        zero_d       = zero_q;
        grant_idx_d  = grant_idx_q;
        req_ready_c  = '0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    req_ready_c = pick_grant;
                    op_d        = '{op: sel_op, a: sel_a, b: sel_b};
                    grant_idx_d = pick_idx;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                result_d     = alu_result;
                zero_d       = alu_zero;
                resp_valid_d = NUM_REQ'(1) << grant_idx_q;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_hs) begin
                    resp_valid_d = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                resp_valid_d = '0;
                state_d      = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Gate with reset so req_ready reads zero while reset is held
    assign bus.req_ready   = req_ready_c & {NUM_REQ{reset_n}};
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = result_q;
    assign bus.resp_zero   = zero_q;
    assign busy            = busy_q;
    assign grant_idx       = grant_idx_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized self-checking bench for alu_share_arbiter with three requesters.
module tb_alu_share_arbiter;
    localparam int unsigned NR = 3;
    localparam int unsigned IW = 2;

    logic          clk;
    logic          reset_n;
    logic          busy;
    logic [IW-1:0] grant_idx;

    alu_share_arbiter_if #(.NUM_REQ(NR)) bus ();

    alu_share_arbiter #(
        .NUM_REQ (NR),
        .IDX_W   (IW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    int last_w;

    logic [31:0] ta  [NR];
    logic [31:0] tbv [NR];
    logic [3:0]  top [NR];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference ALU from the operation definitions
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        int unsigned sh;
        logic signed [31:0] sa;
        sh = 32'(b[4:0]);
        sa = a;
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a ^ b;
            4'd4:    return a << sh;
            4'd5:    return a >> sh;
            4'd6:    return a - b;
            4'd7:    return 32'(sa >>> sh);
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_pick(input logic [NR-1:0] mask);
        logic [NR-1:0] sh;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= int'(NR); k++) begin
            int c;
            c  = (last_w + k) % int'(NR);
            sh = mask >> c;
            if (sh[0]) return c;
        end
`else
        for (int i = 0; i < int'(NR); i++) begin
            sh = mask >> i;
            if (sh[0]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic drive_payload(input logic [NR-1:0] mask);
        bus.req_valid = mask;
        bus.req_a     = {ta[2], ta[1], ta[0]};
        bus.req_b     = {tbv[2], tbv[1], tbv[0]};
        bus.req_op    = {top[2], top[1], top[0]};
    endtask

    // One arbitration round: grant, execute, respond with bp stall cycles
    task automatic run_txn(input logic [NR-1:0] mask, input int bp);
        int          w;
        logic [NR-1:0] wmask;
        logic [31:0] er;
        logic        ez;
        w = model_pick(mask);
        @(negedge clk);
        drive_payload(mask);
        #1;
        if (w < 0) begin
            check_eq("idle_req_ready", 64'(bus.req_ready), 64'd0);
            @(posedge clk); #1;
            check_eq("idle_busy", 64'(busy), 64'd0);
            return;
        end
        wmask = 3'(1) << w;
        er    = alu_ref(ta[w], tbv[w], top[w]);
        ez    = (er == 32'd0);
        check_eq("req_ready", 64'(bus.req_ready), 64'(wmask));
        bus.resp_ready = 3'($urandom_range(0, 7)) & ~wmask;
        @(posedge clk); #1;
        last_w = w;
        check_eq("exec_busy", 64'(busy), 64'd1);
        check_eq("exec_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_eq("grant_idx", 64'(grant_idx), 64'(w));
        check_eq("exec_req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk); #1;
        check_eq("resp_valid", 64'(bus.resp_valid), 64'(wmask));
        check_eq("resp_result", 64'(bus.resp_result), 64'(er));
        check_eq("resp_zero", 64'(bus.resp_zero), 64'(ez));
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check_eq("bp_resp_valid", 64'(bus.resp_valid), 64'(wmask));
            check_eq("bp_resp_result", 64'(bus.resp_result), 64'(er));
            check_eq("bp_req_ready", 64'(bus.req_ready), 64'd0);
            check_eq("bp_busy", 64'(busy), 64'd1);
        end
        @(negedge clk);
        bus.resp_ready = wmask | 3'($urandom_range(0, 7));
        @(posedge clk); #1;
        check_eq("post_hs_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_eq("post_hs_busy", 64'(busy), 64'd0);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
        ta[i]  = a;
        tbv[i] = b;
        top[i] = op;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        last_w = int'(NR) - 1;
        for (int i = 0; i < int'(NR); i++) set_req(i, 32'd0, 32'd0, 4'd0);
        reset_n        = 1'b0;
        bus.resp_ready = '0;
        drive_payload(3'b111);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check_eq("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_eq("rst_result", 64'(bus.resp_result), 64'd0);
        check_eq("rst_zero", 64'(bus.resp_zero), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_grant_idx", 64'(grant_idx), 64'd0);
        @(negedge clk);
        bus.req_valid = '0;
        reset_n       = 1'b1;

        run_txn(3'b000, 0);

        set_req(0, 32'd5, 32'd7, 4'b0010);
        run_txn(3'b001, 0);

        set_req(1, 32'd9, 32'd9, 4'b0110);
        run_txn(3'b010, 0);

        set_req(2, 32'hFFFF_FFFF, 32'd3, 4'b1111);
        run_txn(3'b100, 1);

        set_req(0, 32'h8000_0000, 32'd4, 4'b0111);
        run_txn(3'b001, 0);

        set_req(0, 32'h1234_0000, 32'h0000_5678, 4'b0001);
        run_txn(3'b001, 5);

        // Reset in EXEC aborts the op
        @(negedge clk);
        set_req(1, 32'd100, 32'd1, 4'b0010);
        drive_payload(3'b010);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
        check_eq("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_eq("mid_rst_result", 64'(bus.resp_result), 64'd0);
        check_eq("mid_rst_zero", 64'(bus.resp_zero), 64'd0);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_grant_idx", 64'(grant_idx), 64'd0);
        last_w = int'(NR) - 1;
        @(negedge clk);
        bus.req_valid = '0;
        reset_n       = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("after_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
            check_eq("after_rst_busy", 64'(busy), 64'd0);
        end

        // Contention: all three requesters hold valid
        set_req(0, 32'd1, 32'd1, 4'b0010);
        set_req(1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0011);
        set_req(2, 32'h0000_00F0, 32'h0000_000F, 4'b0001);
        repeat (4) run_txn(3'b111, 0);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < int'(NR); i++) begin
                set_req(i, $urandom, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)),
                        4'($urandom_range(0, 15)));
            end
            run_txn(3'($urandom_range(0, 7)), $urandom_range(0, 3));
        end

        @(negedge clk);
        bus.req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("final_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
